// File: rtl/mem_wb_skid_stage.sv
// MEM->WB pipeline stage with a 2-entry skid buffer (head H + skid S).
// Ports: clk, resetn, flush, in_* (MEM side), out_* (WB side), fwd_* (bypass), occupancy.
module mem_wb_skid_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_read_data,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [RA_W-1:0] in_rd,
  input  logic            in_mem_to_reg,
  input  logic            in_reg_write,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_wb_data,
  output logic [RA_W-1:0] out_rd,
  output logic            out_reg_write,
  output logic            fwd_valid,
  output logic [RA_W-1:0] fwd_rd,
  output logic [XLEN-1:0] fwd_data,
  output logic [1:0]      occupancy
);

  typedef struct packed {
    logic [XLEN-1:0] wb_data;
    logic [RA_W-1:0] rd;
    logic            reg_write;
  } ent_t;

  ent_t h_q, h_d;
  ent_t s_q, s_d;
  logic h_v_q, h_v_d;
  logic s_v_q, s_v_d;
  ent_t cap;
  logic accept;
  logic pop;
  logic pop_s;
  logic pop_h;
  logic push_h;
  logic push_s;

  // Writeback mux resolved at capture; x0 writes dropped here.
  always_comb begin
    cap.wb_data   = in_mem_to_reg ? in_read_data : in_alu_result;
    cap.rd        = in_rd;
    cap.reg_write = in_reg_write & (in_rd != '0);
  end

  // Ready comes only from the skid flop, never from out_ready.
  assign in_ready = ~s_v_q;
  assign accept   = in_valid & in_ready;
  assign pop      = h_v_q & out_ready;

  // Mutually exclusive cases, flush first.
  assign pop_s  = ~flush & pop & s_v_q;
  assign pop_h  = ~flush & pop & ~s_v_q;
  assign push_h = ~flush & ~pop & accept & ~h_v_q;
  assign push_s = ~flush & ~pop & accept & h_v_q;

  always_comb begin
    h_d   = h_q;
    s_d   = s_q;
    h_v_d = h_v_q;
    s_v_d = s_v_q;
    unique case (1'b1)
      flush: begin
        h_v_d = 1'b0;
        s_v_d = 1'b0;
      end
      pop_s: begin
        h_d   = s_q;
        h_v_d = 1'b1;
        s_v_d = accept;
        if (accept) s_d = cap;
      end
      pop_h: begin
        h_v_d = accept;
        if (accept) h_d = cap;
      end
      push_h: begin
        h_d   = cap;
        h_v_d = 1'b1;
      end
      push_s: begin
        s_d   = cap;
        s_v_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_q   <= '0;
      s_q   <= '0;
      h_v_q <= 1'b0;
      s_v_q <= 1'b0;
    end else begin
      h_q   <= h_d;
      s_q   <= s_d;
      h_v_q <= h_v_d;
      s_v_q <= s_v_d;
    end
  end

  assign out_valid     = h_v_q;
  assign out_wb_data   = h_q.wb_data;
  assign out_rd        = h_q.rd;
  assign out_reg_write = h_v_q & h_q.reg_write;
  assign fwd_valid     = out_reg_write;
  assign fwd_rd        = h_q.rd;
  assign fwd_data      = h_q.wb_data;
  // S is never valid without H, so this is the 0/1/2 count.
  assign occupancy     = {h_v_q & s_v_q, h_v_q ^ s_v_q};

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Scoreboard bench for mem_wb_skid_stage.
// Directed vectors; monitor pops expected entries as WB consumes them.
module tb_mem_wb_skid_stage;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_read_data;
  logic [31:0] in_alu_result;
  logic [4:0]  in_rd;
  logic        in_mem_to_reg;
  logic        in_reg_write;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_wb_data;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic [1:0]  occupancy;

  mem_wb_skid_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_read_data(in_read_data), .in_alu_result(in_alu_result),
    .in_rd(in_rd), .in_mem_to_reg(in_mem_to_reg),
    .in_reg_write(in_reg_write),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wb_data(out_wb_data), .out_rd(out_rd),
    .out_reg_write(out_reg_write),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .occupancy(occupancy)
  );

  typedef struct {
    logic [31:0] d;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   n_vec = 0;
  int   n_miss = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  // Inputs plus the hand-computed expected writeback for this entry.
  task automatic drive(input logic [4:0] rd, input logic m2r,
                       input logic rw, input logic [31:0] rdat,
                       input logic [31:0] alu, input logic [31:0] ed,
                       input logic erw);
    in_valid      = 1'b1;
    in_rd         = rd;
    in_mem_to_reg = m2r;
    in_reg_write  = rw;
    in_read_data  = rdat;
    in_alu_result = alu;
    cur.d  = ed;
    cur.rd = rd;
    cur.rw = erw;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic cycle();
    @(negedge clk);
    if (in_valid && in_ready && !flush && resetn) q.push_back(cur);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      n_vec++;
      if (q.size() == 0) begin
        n_miss++;
        $display("FAIL mon_extra: got d=%0h rd=%0d want none",
                 out_wb_data, out_rd);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (out_wb_data !== e.d || out_rd !== e.rd ||
            out_reg_write !== e.rw) begin
          n_miss++;
          $display("FAIL mon_entry: got d=%0h rd=%0d rw=%0b want d=%0h rd=%0d rw=%0b",
                   out_wb_data, out_rd, out_reg_write, e.d, e.rd, e.rw);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b0;
    in_rd = '0;
    in_mem_to_reg = 1'b0;
    in_reg_write = 1'b0;
    in_read_data = '0;
    in_alu_result = '0;
    cur = '{d: 32'h0, rd: 5'd0, rw: 1'b0};
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_reg_write", out_reg_write, 0);
    chk("rst_fwd_valid", fwd_valid, 0);
    chk("rst_wb_data", out_wb_data, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // 1: streaming, 1-cycle latency
    out_ready = 1'b1;
    drive(5'd1, 1'b0, 1'b1, 32'h0, 32'hA, 32'hA, 1'b1);
    cycle();
    chk("t1_a_valid", out_valid, 1);
    chk("t1_a_data", out_wb_data, 32'hA);
    chk("t1_a_occ", occupancy, 1);
    drive(5'd2, 1'b1, 1'b1, 32'hB0B, 32'h99, 32'hB0B, 1'b1);
    cycle();
    chk("t1_b_data", out_wb_data, 32'hB0B);
    chk("t1_b_occ", occupancy, 1);
    chk("t1_b_ready", in_ready, 1);
    drive(5'd3, 1'b0, 1'b0, 32'h0, 32'hC, 32'hC, 1'b0);
    cycle();
    chk("t1_c_data", out_wb_data, 32'hC);
    chk("t1_c_ready", in_ready, 1);
    idle();
    cycle();
    chk("t1_drain_valid", out_valid, 0);
    chk("t1_drain_occ", occupancy, 0);

    // 2: stall fills skid, then drain in order
    out_ready = 1'b0;
    drive(5'd4, 1'b0, 1'b1, 32'h0, 32'h100, 32'h100, 1'b1);
    cycle();
    chk("t2_a_occ", occupancy, 1);
    chk("t2_a_ready", in_ready, 1);
    drive(5'd6, 1'b0, 1'b1, 32'h0, 32'h200, 32'h200, 1'b1);
    cycle();
    chk("t2_b_occ", occupancy, 2);
    chk("t2_b_ready", in_ready, 0);
    drive(5'd7, 1'b0, 1'b1, 32'h0, 32'h300, 32'h300, 1'b1);
    cycle();
    chk("t2_c_held_occ", occupancy, 2);
    chk("t2_head_a", out_wb_data, 32'h100);
    out_ready = 1'b1;
    cycle();
    chk("t2_pop_occ", occupancy, 1);
    chk("t2_pop_ready", in_ready, 1);
    chk("t2_head_b", out_wb_data, 32'h200);
    cycle();
    chk("t2_head_c", out_wb_data, 32'h300);
    chk("t2_c_occ", occupancy, 1);
    idle();
    cycle();
    chk("t2_empty", occupancy, 0);

    // 3: writeback mux
    drive(5'd8, 1'b1, 1'b1, 32'hDEADBEEF, 32'h10, 32'hDEADBEEF, 1'b1);
    cycle();
    chk("t3_load", out_wb_data, 32'hDEADBEEF);
    drive(5'd8, 1'b0, 1'b1, 32'hDEADBEEF, 32'h10, 32'h10, 1'b1);
    cycle();
    chk("t3_alu", out_wb_data, 32'h10);

    // 4: x0 suppression and forwarding
    drive(5'd0, 1'b0, 1'b1, 32'h0, 32'h55, 32'h55, 1'b0);
    cycle();
    chk("t4_x0_valid", out_valid, 1);
    chk("t4_x0_rw", out_reg_write, 0);
    chk("t4_x0_fwd", fwd_valid, 0);
    drive(5'd5, 1'b0, 1'b1, 32'h0, 32'h66, 32'h66, 1'b1);
    cycle();
    chk("t4_r5_rw", out_reg_write, 1);
    chk("t4_r5_fwd", fwd_valid, 1);
    chk("t4_r5_fwd_rd", fwd_rd, 5);
    chk("t4_r5_fwd_data", fwd_data, 32'h66);
    idle();
    cycle();
    chk("t4_idle_fwd", fwd_valid, 0);
    chk("t4_idle_rw", out_reg_write, 0);
    chk("t4_stale_rd", out_rd, 5);

    // 5: flush when full, with an incoming entry
    out_ready = 1'b0;
    drive(5'd9, 1'b0, 1'b1, 32'h0, 32'h900, 32'h900, 1'b1);
    cycle();
    drive(5'd10, 1'b0, 1'b1, 32'h0, 32'hA00, 32'hA00, 1'b1);
    cycle();
    chk("t5_full", occupancy, 2);
    drive(5'd11, 1'b0, 1'b1, 32'h0, 32'hB00, 32'hB00, 1'b1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    idle();
    q.delete();
    chk("t5_occ", occupancy, 0);
    chk("t5_valid", out_valid, 0);
    chk("t5_ready", in_ready, 1);
    out_ready = 1'b1;
    cycle();
    chk("t5_nothing", out_valid, 0);

    // 6: async reset pulse between edges while full
    out_ready = 1'b0;
    drive(5'd12, 1'b0, 1'b1, 32'h0, 32'hC00, 32'hC00, 1'b1);
    cycle();
    drive(5'd13, 1'b0, 1'b1, 32'h0, 32'hD00, 32'hD00, 1'b1);
    cycle();
    chk("t6_full", occupancy, 2);
    idle();
    #1;
    resetn = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_occ", occupancy, 0);
    chk("t6_rst_ready", in_ready, 1);
    chk("t6_rst_fwd", fwd_valid, 0);
    chk("t6_rst_data", out_wb_data, 0);
    chk("t6_rst_rd", out_rd, 0);
    q.delete();
    #1;
    resetn = 1'b1;
    out_ready = 1'b1;
    drive(5'd14, 1'b1, 1'b1, 32'hD0D0, 32'h0, 32'hD0D0, 1'b1);
    cycle();
    chk("t6_d_valid", out_valid, 1);
    chk("t6_d_data", out_wb_data, 32'hD0D0);
    idle();
    cycle();
    chk("t6_d_drained", out_valid, 0);

    chk("sb_drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
